// File: rtl/coherent_dcache_if.sv
// Signal bundle between coherent_dcache, the core datapath port and one coherence-bus slot.
// With COHERENT_DCACHE_STATS_EN defined the bundle also carries hitcount/misscount.
interface coherent_dcache_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        cctrans;
    logic        ccwrite;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
`ifdef COHERENT_DCACHE_STATS_EN
    logic [31:0] hitcount;
    logic [31:0] misscount;
`endif

    modport master (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        input  dload, dwait, ccwait, ccinv, ccsnoopaddr,
        output dhit, dmemload, flushed,
        output dREN, dWEN, daddr, dstore, cctrans, ccwrite
`ifdef COHERENT_DCACHE_STATS_EN
        , output hitcount, misscount
`endif
    );

    modport slave (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
        output dload, dwait, ccwait, ccinv, ccsnoopaddr,
        input  dhit, dmemload, flushed,
        input  dREN, dWEN, daddr, dstore, cctrans, ccwrite
`ifdef COHERENT_DCACHE_STATS_EN
        , input hitcount, misscount
`endif
    );
endinterface

// File: rtl/coherent_dcache.sv
// Direct-mapped, one-word-block MSI data cache with snoop response and flush-on-halt.
// Optional macro COHERENT_DCACHE_STATS_EN adds hit/miss counters and a hit-count write at flush end.
module coherent_dcache #(
    parameter int SETS  = 16,
    parameter int CPUID = 0
) (
    input logic               CLK,
    input logic               nRST,
    coherent_dcache_if.master bus
);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;
    localparam logic [IDX-1:0] LAST_IDX = IDX'(SETS - 1);

    typedef enum logic [2:0] {IDLE, WB, REQ, SNOOP_WB, FLUSH, HALTED} state_t;
    typedef enum logic [1:0] {LINE_I, LINE_S, LINE_M} line_t;

    if (SETS < 2 || (SETS & (SETS - 1)) != 0 || CPUID < 0) begin : g_bad_param
        $error("coherent_dcache: SETS must be a power of two >= 2 and CPUID >= 0");
    end

    state_t          r_state, w_state_next, r_ret_state;
    line_t           r_line [SETS];
    logic [TAGW-1:0] r_tag  [SETS];
    logic [31:0]     r_data [SETS];
    logic [IDX-1:0]  r_flush_idx, r_snp_idx;
    logic            r_snp_inv, r_flushed;

    logic [IDX-1:0]  w_req_idx, w_snp_idx;
    logic [TAGW-1:0] w_req_tag, w_snp_tag;
    logic            w_req_hit, w_snp_hit, w_snp_eval, w_snp_go, w_snp_inv;
    logic            w_fill, w_store_hit, w_wb_done, w_snpwb_done;
    logic            w_flush_wb_done, w_flush_step, w_go_halted, w_miss;
    logic            w_unused;

`ifdef COHERENT_DCACHE_STATS_EN
    logic [31:0] r_hitcount, r_misscount;
    logic        r_stat_phase;
`endif

    assign w_req_idx = bus.dmemaddr[IDX+1:2];
    assign w_req_tag = bus.dmemaddr[31:IDX+2];
    assign w_snp_idx = bus.ccsnoopaddr[IDX+1:2];
    assign w_snp_tag = bus.ccsnoopaddr[31:IDX+2];
    assign w_req_hit = (r_line[w_req_idx] != LINE_I) && (r_tag[w_req_idx] == w_req_tag);
    assign w_snp_hit = (r_line[w_snp_idx] != LINE_I) && (r_tag[w_snp_idx] == w_snp_tag);

    // Snoops are answered in every state that is not itself driving a bus write.
    assign w_snp_eval = bus.ccwait && (r_state == IDLE || r_state == REQ ||
                                       r_state == FLUSH || r_state == HALTED);
    assign w_snp_go   = w_snp_eval && w_snp_hit && (r_line[w_snp_idx] == LINE_M);
    assign w_snp_inv  = w_snp_eval && w_snp_hit && (r_line[w_snp_idx] == LINE_S) && bus.ccinv;
    assign bus.flushed = r_flushed;

    always_comb begin
        w_state_next    = r_state;
        bus.dhit        = 1'b0;
        bus.dmemload    = '0;
        bus.dREN        = 1'b0;
        bus.dWEN        = 1'b0;
        bus.daddr       = '0;
        bus.dstore      = '0;
        bus.cctrans     = 1'b0;
        bus.ccwrite     = 1'b0;
        w_fill          = 1'b0;
        w_store_hit     = 1'b0;
        w_wb_done       = 1'b0;
        w_snpwb_done    = 1'b0;
        w_flush_wb_done = 1'b0;
        w_flush_step    = 1'b0;
        w_go_halted     = 1'b0;
        w_miss          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_snp_go) begin
                    w_state_next = SNOOP_WB;
                end else if (!bus.ccwait) begin
                    if (bus.halt) begin
                        w_state_next = FLUSH;
                    end else if (bus.dmemREN || bus.dmemWEN) begin
                        if (w_req_hit && bus.dmemREN) begin
                            bus.dhit     = 1'b1;
                            bus.dmemload = r_data[w_req_idx];
                        end else if (w_req_hit && r_line[w_req_idx] == LINE_M) begin
                            bus.dhit    = 1'b1;
                            w_store_hit = 1'b1;
                        end else if (!w_req_hit && r_line[w_req_idx] == LINE_M) begin
                            w_state_next = WB;
                        end else begin
                            w_state_next = REQ;
                            w_miss       = 1'b1;
                        end
                    end
                end
            end
            WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {r_tag[w_req_idx], w_req_idx, 2'b00};
                bus.dstore = r_data[w_req_idx];
                if (!bus.dwait) begin
                    w_wb_done    = 1'b1;
                    w_miss       = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (w_snp_go) begin
                    w_state_next = SNOOP_WB;
                end else begin
                    bus.dREN    = 1'b1;
                    bus.cctrans = 1'b1;
                    bus.ccwrite = bus.dmemWEN;
                    bus.daddr   = bus.dmemaddr;
                    if (!bus.dwait) begin
                        w_fill       = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            SNOOP_WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = bus.ccsnoopaddr;
                bus.dstore = r_data[r_snp_idx];
                if (!bus.dwait) begin
                    w_snpwb_done = 1'b1;
                    w_state_next = r_ret_state;
                end
            end
            FLUSH: begin
                if (w_snp_go) begin
                    w_state_next = SNOOP_WB;
`ifdef COHERENT_DCACHE_STATS_EN
                end else if (r_stat_phase) begin
                    bus.dWEN   = 1'b1;
                    bus.daddr  = 32'h0000_3100;
                    bus.dstore = r_hitcount;
                    if (!bus.dwait) begin
                        w_go_halted  = 1'b1;
                        w_state_next = HALTED;
                    end
`endif
                end else begin
                    if (r_line[r_flush_idx] == LINE_M) begin
                        bus.dWEN   = 1'b1;
                        bus.daddr  = {r_tag[r_flush_idx], r_flush_idx, 2'b00};
                        bus.dstore = r_data[r_flush_idx];
                        if (!bus.dwait) begin
                            w_flush_wb_done = 1'b1;
                            w_flush_step    = 1'b1;
                        end
                    end else begin
                        w_flush_step = 1'b1;
                    end
`ifndef COHERENT_DCACHE_STATS_EN
                    if (w_flush_step && r_flush_idx == LAST_IDX) begin
                        w_go_halted  = 1'b1;
                        w_state_next = HALTED;
                    end
`endif
                end
            end
            HALTED: begin
                if (w_snp_go) w_state_next = SNOOP_WB;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_ret_state <= IDLE;
            r_snp_idx   <= '0;
            r_snp_inv   <= 1'b0;
            r_flush_idx <= '0;
            r_flushed   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state != SNOOP_WB && w_state_next == SNOOP_WB) begin
                r_ret_state <= r_state;
                r_snp_idx   <= w_snp_idx;
                r_snp_inv   <= bus.ccinv;
            end
            if (r_state == IDLE && w_state_next == FLUSH)
                r_flush_idx <= '0;
            else if (w_flush_step && r_flush_idx != LAST_IDX)
                r_flush_idx <= r_flush_idx + 1'b1;
            if (w_go_halted)
                r_flushed <= 1'b1;
        end
    end

    // Snoop updates come before the fill so a same-index fill wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) r_line[i] <= LINE_I;
        end else begin
            if (w_snp_inv)       r_line[w_snp_idx]   <= LINE_I;
            if (w_snpwb_done)    r_line[r_snp_idx]   <= r_snp_inv ? LINE_I : LINE_S;
            if (w_wb_done)       r_line[w_req_idx]   <= LINE_I;
            if (w_flush_wb_done) r_line[r_flush_idx] <= LINE_I;
            if (w_fill)          r_line[w_req_idx]   <= bus.dmemWEN ? LINE_M : LINE_S;
            if (w_go_halted)
                for (int i = 0; i < SETS; i++) r_line[i] <= LINE_I;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_req_idx]  <= w_req_tag;
            r_data[w_req_idx] <= bus.dmemWEN ? bus.dmemstore : bus.dload;
        end else if (w_store_hit) begin
            r_data[w_req_idx] <= bus.dmemstore;
        end
    end

`ifdef COHERENT_DCACHE_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hitcount   <= '0;
            r_misscount  <= '0;
            r_stat_phase <= 1'b0;
        end else begin
            if (bus.dhit && r_hitcount != 32'hFFFF_FFFF) r_hitcount <= r_hitcount + 1'b1;
            if (w_miss && r_misscount != 32'hFFFF_FFFF)  r_misscount <= r_misscount + 1'b1;
            if (w_go_halted)
                r_stat_phase <= 1'b0;
            else if (w_flush_step && r_flush_idx == LAST_IDX)
                r_stat_phase <= 1'b1;
        end
    end

    assign bus.hitcount  = r_hitcount;
    assign bus.misscount = r_misscount;
    assign w_unused      = ^{bus.dmemaddr[1:0], bus.ccsnoopaddr[1:0]};
`else
    assign w_unused      = ^{bus.dmemaddr[1:0], bus.ccsnoopaddr[1:0], w_miss};
`endif
endmodule

// File: tb/tb_coherent_dcache.sv
// Self-checking bench for coherent_dcache: op table with a load scoreboard, a latency-3 bus
// responder with a memory model, and hand-written snoop / flush / reset sequences.
module tb_coherent_dcache;
    localparam int LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    coherent_dcache_if bus ();
    coherent_dcache #(.SETS(16), .CPUID(0)) dut (.CLK(clk), .nRST(rst_n), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    logic [1:0] last_rd_cc = 2'b00;

    typedef struct { logic [31:0] a; logic [31:0] d; logic cc; int ord; } wr_t;
    wr_t wr_log [$];
    logic [31:0] mem [logic [31:0]];

    typedef struct { logic is_load; logic [31:0] val; } exp_t;
    exp_t exp_q [$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_load;
        int          exp_rd;
        int          exp_wr;
        logic [1:0]  exp_cc;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Bus responder: holds dwait high LAT cycles per access, then completes it.
    initial begin
        int  lat_cnt;
        wr_t e;
        lat_cnt   = 0;
        bus.dwait = 1'b1;
        bus.dload = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || !(bus.dREN || bus.dWEN)) begin
                bus.dwait = 1'b1;
                lat_cnt   = 0;
            end else if (lat_cnt < LAT) begin
                lat_cnt++;
                bus.dwait = 1'b1;
            end else begin
                bus.dwait = 1'b0;
                lat_cnt   = 0;
                if (bus.dREN) begin
                    if (mem.exists(bus.daddr)) bus.dload = mem[bus.daddr];
                    else                       bus.dload = bus.daddr ^ 32'h5A5A_0000;
                    last_rd_cc = {bus.cctrans, bus.ccwrite};
                    rd_cnt++;
                end else begin
                    mem[bus.daddr] = bus.dstore;
                    e.a   = bus.daddr;
                    e.d   = bus.dstore;
                    e.cc  = bus.cctrans;
                    e.ord = rd_cnt;
                    wr_log.push_back(e);
                    wr_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic run_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got, output int nrd, output int nwr, output bit ok);
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        ok  = 1'b0;
        got = '0;
        @(negedge clk);
        bus.dmemREN   = !we;
        bus.dmemWEN   = we;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (bus.dhit) begin
                got = bus.dmemload;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        nrd = rd_cnt - rd0;
        nwr = wr_cnt - wr0;
    endtask

    task automatic run_vec(input int i);
        logic [31:0] got;
        int          nrd;
        int          nwr;
        int          rd_before;
        bit          ok;
        exp_t        e;
        e.is_load = !tbl[i].we;
        e.val     = tbl[i].exp_load;
        exp_q.push_back(e);
        run_op(tbl[i].we, tbl[i].addr, tbl[i].data, got, nrd, nwr, ok);
        rd_before = rd_cnt - nrd;
        chk("op_done", 32'(ok), 32'd1);
        if (ok) begin
            e = exp_q.pop_front();
            if (e.is_load) chk("load_data", got, e.val);
        end else begin
            exp_q.delete();
        end
        chk("bus_reads", 32'(nrd), 32'(tbl[i].exp_rd));
        chk("bus_writes", 32'(nwr), 32'(tbl[i].exp_wr));
        if (tbl[i].exp_rd > 0) chk("cc_flags", 32'(last_rd_cc), 32'(tbl[i].exp_cc));
        if (tbl[i].exp_wr > 0 && wr_log.size() > 0) begin
            chk("wb_addr", wr_log[$].a, tbl[i].exp_wa);
            chk("wb_data", wr_log[$].d, tbl[i].exp_wd);
            chk("wb_cctrans", 32'(wr_log[$].cc), 32'd0);
            chk("wb_before_req", 32'(wr_log[$].ord), 32'(rd_before));
        end
        $display("vec %0d %s addr=%h data=%h got=%h rd=%0d wr=%0d", i,
                 tbl[i].we ? "ST" : "LD", tbl[i].addr, tbl[i].data, got, nrd, nwr);
    endtask

    initial begin
        logic [31:0] got;
        int          nrd;
        int          nwr;
        int          wr0;
        int          rd0;
        int          n0;
        int          bad;
        bit          ok;
        bit          seen;

        bus.dmemREN = 0; bus.dmemWEN = 0; bus.dmemaddr = 0; bus.dmemstore = 0;
        bus.halt = 0; bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
        mem[32'h100] = 32'h0000_DEAD;

        //          we    addr          data          exp_load      rd wr cc     wb addr       wb data
        tbl[0]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_DEAD, 1, 0, 2'b10, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_DEAD, 0, 0, 2'b00, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 32'h0000_0100, 32'h0000_1234, 32'h0,        1, 0, 2'b11, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_1234, 0, 0, 2'b00, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_1234, 1, 0, 2'b10, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 32'h0000_0140, 32'h0000_0011, 32'h0,        1, 0, 2'b11, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 32'h0000_017C, 32'h0000_0022, 32'h0,        1, 0, 2'b11, 32'h0,        32'h0};
        tbl[7]  = '{1'b1, 32'h0000_0040, 32'h0000_0033, 32'h0,        1, 1, 2'b11, 32'h0000_0140, 32'h0000_0011};
        tbl[8]  = '{1'b0, 32'h0000_0040, 32'h0,        32'h0000_0033, 0, 0, 2'b00, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 32'h0000_0140, 32'h0,        32'h0000_0011, 1, 1, 2'b10, 32'h0000_0040, 32'h0000_0033};
        tbl[10] = '{1'b1, 32'h0000_0140, 32'h0000_0044, 32'h0,        1, 0, 2'b11, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 32'h0000_017C, 32'h0,        32'h0000_0022, 0, 0, 2'b00, 32'h0,        32'h0};

        #1 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", 32'({bus.dhit, bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite, bus.flushed}), 32'd0);
        chk("reset_daddr", bus.daddr, 32'h0);
        chk("reset_dstore", bus.dstore, 32'h0);
        chk("reset_dmemload", bus.dmemload, 32'h0);
        $display("reset checked");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(i);

        // M line snooped with invalidate: written back, then gone.
        @(negedge clk);
        bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h100; bus.ccinv = 1'b1;
        wr0 = wr_cnt;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.dWEN && !seen) begin
                seen = 1'b1;
                chk("snoop_wb_addr", bus.daddr, 32'h100);
                chk("snoop_wb_data", bus.dstore, 32'h1234);
                chk("snoop_wb_cctrans", 32'(bus.cctrans), 32'd0);
            end
            if (wr_cnt != wr0) break;
            @(negedge clk);
        end
        bus.ccwait = 1'b0; bus.ccinv = 1'b0;
        chk("snoop_wb_seen", 32'(seen), 32'd1);
        chk("snoop_wb_count", 32'(wr_cnt - wr0), 32'd1);
        $display("snoop M inv: writes=%0d", wr_cnt - wr0);

        run_vec(4);

        // S line snooped without invalidate while a load hit waits.
        @(negedge clk);
        bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h100; bus.ccinv = 1'b0;
        bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
        wr0 = wr_cnt; rd0 = rd_cnt; bad = 0;
        repeat (3) begin
            #1;
            if (bus.dhit || bus.dWEN || bus.dREN) bad++;
            @(negedge clk);
        end
        bus.ccwait = 1'b0;
        #1;
        chk("snoop_s_defers_hit", 32'(bad), 32'd0);
        chk("snoop_s_hit_after", 32'(bus.dhit), 32'd1);
        chk("snoop_s_load", bus.dmemload, 32'h1234);
        @(posedge clk);
        #1 bus.dmemREN = 1'b0;
        chk("snoop_s_no_bus", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
        $display("snoop S keep: deferred_errors=%0d", bad);

        for (int i = 5; i < 12; i++) run_vec(i);

        // Flush with two M lines (index 0 and 15).
        n0 = wr_log.size();
        @(negedge clk);
        bus.halt = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (bus.flushed) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("flush_done", 32'(seen), 32'd1);
        chk("flush_wb_count", 32'(wr_log.size() - n0), 32'd2);
        if (wr_log.size() - n0 == 2) begin
            chk("flush_wb0_addr", wr_log[n0].a, 32'h140);
            chk("flush_wb0_data", wr_log[n0].d, 32'h44);
            chk("flush_wb1_addr", wr_log[n0 + 1].a, 32'h17C);
            chk("flush_wb1_data", wr_log[n0 + 1].d, 32'h22);
            chk("flush_wb_cctrans", 32'({wr_log[n0].cc, wr_log[n0 + 1].cc}), 32'd0);
        end
        repeat (5) @(negedge clk);
        #1;
        chk("flushed_sticky", 32'(bus.flushed), 32'd1);
        chk("halted_bus_idle", 32'({bus.dREN, bus.dWEN}), 32'd0);
        $display("flush: writebacks=%0d flushed=%0b", wr_log.size() - n0, bus.flushed);

        // Reset clears flushed; then reset again in the middle of a flush writeback.
        @(negedge clk);
        bus.halt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("reset_clears_flushed", 32'(bus.flushed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 32'h140, 32'h55, got, nrd, nwr, ok);
        chk("refill_st0_done", 32'(ok), 32'd1);
        run_op(1'b1, 32'h17C, 32'h66, got, nrd, nwr, ok);
        chk("refill_st1_done", 32'(ok), 32'd1);
        @(negedge clk);
        bus.halt = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.dWEN) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midflush_wb_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midflush_rst_ctrl", 32'({bus.dREN, bus.dWEN, bus.cctrans, bus.flushed, bus.dhit}), 32'd0);
        chk("midflush_rst_daddr", bus.daddr, 32'h0);
        chk("midflush_rst_dstore", bus.dstore, 32'h0);
        bus.halt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'h140, 32'h0, got, nrd, nwr, ok);
        chk("post_rst_load_done", 32'(ok), 32'd1);
        chk("post_rst_load_miss", 32'(nrd), 32'd1);
        chk("post_rst_load_data", got, 32'h44);
        $display("mid-flush reset: reload got=%h rd=%0d", got, nrd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coherent_dcache.md
Name: coherent_dcache

Overview:
Per-core, cache-side end of the coherence bus. It is a direct-mapped, one-word-block MSI data cache that drives dREN/dWEN/cctrans/ccwrite toward the memory controller. It answers snoops delivered via ccwait/ccsnoopaddr/ccinv. It sits between the core's datapath memory port and one slot of the cache_control_if bus; on halt it flushes dirty lines.

Parameters:
SETS, 16, number of lines (power of 2, ≥2); IDX = log2(SETS); tag = addr[31:IDX+2]
CPUID, 0, core index, informational only

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
dmemREN  in  1  datapath load request
dmemWEN  in  1  datapath store request (never both with dmemREN)
dmemaddr  in  32  word address, bits[1:0]=0
dmemstore  in  32  store data
halt  in  1  core halted; start flush
dhit  out  1  request completed this cycle
dmemload  out  32  load data, valid when dhit
flushed  out  1  flush complete, sticky until reset
dREN  out  1  bus read
dWEN  out  1  bus write
daddr  out  32  bus address
dstore  out  32  bus write data
dload  in  32  bus read data
dwait  in  1  bus stall; 0 = current access completes
cctrans  out  1  coherent transaction request
ccwrite  out  1  transaction is for ownership (invalidate others)
ccwait  in  1  this cache is snoop target this cycle
ccinv  in  1  invalidate snooped line
ccsnoopaddr  in  32  snooped address

Behaviour:
- Reset: all lines I, dirty=0, FSM IDLE; dhit, dREN, dWEN, cctrans, ccwrite, flushed = 0; dmemload, daddr, dstore = 0.
- Line: valid/state {I,S,M}, tag, 32-bit data. M implies dirty.
- FSM states: IDLE, WB, REQ, SNOOP_WB, FLUSH, HALTED.
- IDLE, ccwait=0:
  - Load hit (S/M) → dhit=1, dmemload=data, same cycle.
  - Store hit on M → write data, dhit=1.
  - Store hit on S → REQ with ccwrite=1 (upgrade).
  - Miss with victim M → WB.
  - Other miss → REQ.
- WB: dWEN=1, cctrans=0, daddr=victim address, dstore=victim data, held until dwait=0; then victim←I, go REQ.
- REQ: dREN=1, cctrans=1, ccwrite=dmemWEN, daddr=dmemaddr, held until dwait=0.
  - On completion, fill line: tag, data=dload (store overrides with dmemstore), state S for load, M for store.
  - dhit=1 in the cycle after the fill, from IDLE lookup; go IDLE.
- Snoop (ccwait=1): evaluated in IDLE and REQ; takes priority over a new datapath hit, so dhit=0 while ccwait=1.
  - Hit on M → SNOOP_WB: dWEN=1, daddr=ccsnoopaddr, dstore=line data until dwait=0; then line→I if ccinv else S; return to prior state with the pending request retained.
  - Hit on S with ccinv → I, same cycle, no bus activity.
  - Miss → no action.
- Own fill vs. snoop of same index in REQ: the snoop is processed first; the fill overwrites after.
- halt (checked only in IDLE with ccwait=0) → FLUSH.
  - FLUSH scans index 0..SETS-1; each M line is written back as in WB, with cctrans=0; non-M lines are skipped one per cycle.
  - After the last index → HALTED; flushed=1, all lines I.
  - Snoops are still serviced during FLUSH/HALTED.
- Index counter in FLUSH saturates at SETS-1; no wrap.
- Reset asserted mid-transaction: bus outputs drop asynchronously, contents lost.
- daddr/dstore are 0 whenever dREN=dWEN=0.

Optional Feature:
COHERENT_DCACHE_STATS_EN defined:
- Adds outputs hitcount[31:0] and misscount[31:0].
- Counters increment on datapath hit and on entry to REQ, saturating at 32'hFFFFFFFF; reset to 0.
- During FLUSH, a write of 32'h3100 with dstore=hitcount is issued after the last line.
Undefined: ports and write are absent; behaviour is otherwise identical.

Test Plan:
- Load 0x100 cold, dload=0xDEAD, dwait low after 3 cycles → REQ dREN=1 cctrans=1 ccwrite=0; dhit with dmemload=0xDEAD; reload is dhit same cycle.
- Store 0x100 ← 0x1234 on S line → cctrans=1 ccwrite=1; line M; later load returns 0x1234 with no bus activity.
- Line 0x100 M=0x1234; ccwait=1, ccsnoopaddr=0x100, ccinv=1 → dWEN=1 daddr=0x100 dstore=0x1234 until dwait=0; line I; next load misses.
- Line 0x100 S; ccwait=1 ccsnoopaddr=0x100 ccinv=0 → no dWEN, line stays S; a simultaneous load hit is deferred until ccwait=0.
- SETS=16, M lines at index 0x140 (idx 0) and 0x17C (idx 15) in conflict with 0x40 → store to 0x40 issues WB of 0x140 first (dWEN, cctrans=0), then REQ.
- Two M lines, halt=1 → exactly two dWEN writebacks in index order, then flushed=1 and it stays high; nRST low mid-flush clears flushed and all outputs.
